// File: rtl/stg3_pkg.sv
// Shared definitions for the stage-3 accumulator slice.
//   Q0, Q1        : lane moduli (lane 1 uses Q0, lane 0 uses Q1)
//   Q0X2, Q1X2    : doubled moduli, the lazy-reduction bound
//   state_t       : accumulator control states
//   mod_of_lane() : lane-to-modulus mapping shared with downstream stg3_sub
package stg3_pkg;

  localparam logic [34:0] Q0   = 35'h4_0800_0001;
  localparam logic [34:0] Q1   = 35'h4_0008_0001;
  localparam logic [35:0] Q0X2 = {Q0, 1'b0};
  localparam logic [35:0] Q1X2 = {Q1, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  // Lane 0 reduces by q1 and lane 1 by q0 (crossed on purpose, matches stg3_sub).
  function automatic logic [34:0] mod_of_lane(input int unsigned lane,
                                              input logic [34:0] q0,
                                              input logic [34:0] q1);
    return (lane == 0) ? q1 : q0;
  endfunction

endpackage

// File: rtl/stg3_modadd.sv
// One-lane lazy modular adder: o_sum = (i_a + i_b) with a single conditional
// subtract of 2Q. With i_a, i_b < 2Q the result stays in [0, 2Q).
//   i_a   : running accumulator, 36 bits
//   i_b   : new term, 36 bits
//   o_sum : reduced sum, 36 bits
module stg3_modadd #(
  parameter logic [34:0] Q = 35'h4_0800_0001
) (
  input  logic [35:0] i_a,
  input  logic [35:0] i_b,
  output logic [35:0] o_sum
);

  localparam logic [36:0] Q2 = {1'b0, Q, 1'b0};

  logic [36:0] w_s;
  logic [36:0] w_d;

  assign w_s = {1'b0, i_a} + {1'b0, i_b};
  assign w_d = w_s - Q2;

  always_comb begin
    o_sum = w_s[35:0];
    if (w_s >= Q2) begin
      o_sum = w_d[35:0];
    end
  end

endmodule

// File: rtl/stg3_acc.sv
// Stage-3 lazy modular accumulator feeding stg3_sub. Sums N_TERM consecutive
// beats per coefficient address, per lane, modulo 2Q, and issues one write per
// coefficient with each lane value in [0, 2Q).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : frame start (IDLE only), i_len = coefficients in frame
//   i_valid   : beat valid, o_ready = beat accepted (ACC state)
//   i_addr    : coefficient address, i_data = per-lane terms (flat, lane l at l*DATA_WIDTH)
//   o_we      : per-lane write strobe, o_addr/o_data = flat per-lane write bus
//   o_busy    : frame in progress, o_done = one-cycle frame-complete pulse
//   o_err     : sticky error (address mismatch within a group, plus input range)
// Build option: define STG3_ACC_IN_CHK_EN to range-check and fold lane inputs >= 2Q.
module stg3_acc #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [34:0] Q0         = stg3_pkg::Q0,
  parameter logic [34:0] Q1         = stg3_pkg::Q1,
  parameter int unsigned N_POLY_SUB = 2,
  parameter int unsigned N_TERM     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH:0]              i_len,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [N_POLY_SUB*DATA_WIDTH-1:0] i_data,
  output logic [N_POLY_SUB-1:0]            o_we,
  output logic [N_POLY_SUB*ADDR_WIDTH-1:0] o_addr,
  output logic [N_POLY_SUB*DATA_WIDTH-1:0] o_data,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  import stg3_pkg::*;

  localparam int unsigned TW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam logic [TW-1:0] TLAST = TW'(N_TERM - 1);

  state_t r_state;
  state_t w_next;

  logic [TW-1:0]                    r_tcnt;
  logic [ADDR_WIDTH:0]              r_ccnt;
  logic [ADDR_WIDTH:0]              r_len;
  logic [ADDR_WIDTH-1:0]            r_first_addr;
  logic [35:0]                      r_acc [N_POLY_SUB];
  logic [N_POLY_SUB-1:0]            r_we;
  logic [N_POLY_SUB*ADDR_WIDTH-1:0] r_addr;
  logic [N_POLY_SUB*DATA_WIDTH-1:0] r_data;
  logic                             r_err;

  logic        w_accept;
  logic        w_last_term;
  logic        w_last_coef;
  logic [35:0] w_x   [N_POLY_SUB];
  logic [35:0] w_sum [N_POLY_SUB];
  logic [35:0] w_new [N_POLY_SUB];
  logic [N_POLY_SUB-1:0] w_rng_err;

  assign w_accept    = i_valid && (r_state == ACC);
  assign w_last_term = (r_tcnt == TLAST);
  assign w_last_coef = (r_ccnt == (r_len - (ADDR_WIDTH+1)'(1)));

  for (genvar l = 0; l < N_POLY_SUB; l++) begin : g_lane
    localparam logic [34:0] QL  = mod_of_lane(l, Q0, Q1);
    localparam logic [63:0] Q2L = {28'd0, QL, 1'b0};
    localparam logic [63:0] Q4L = {27'd0, QL, 2'b00};

    logic [DATA_WIDTH-1:0] w_raw;
    logic [35:0]           w_xl;
    logic                  w_el;

    assign w_raw = i_data[l*DATA_WIDTH +: DATA_WIDTH];

`ifdef STG3_ACC_IN_CHK_EN
    // Out-of-range terms are folded back below 2Q so the accumulator invariant holds.
    always_comb begin
      w_xl = w_raw[35:0];
      w_el = 1'b0;
      if (w_raw >= DATA_WIDTH'(Q2L)) begin
        w_el = 1'b1;
        if (w_raw < DATA_WIDTH'(Q4L)) begin
          w_xl = 36'(w_raw - DATA_WIDTH'(Q2L));
        end else begin
          w_xl = '0;
        end
      end
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{w_raw, Q4L, Q2L};
    assign w_xl = w_raw[35:0];
    assign w_el = 1'b0;
`endif

    assign w_x[l]       = w_xl;
    assign w_rng_err[l] = w_el;

    stg3_modadd #(
      .Q(QL)
    ) u_modadd (
      .i_a  (r_acc[l]),
      .i_b  (w_xl),
      .o_sum(w_sum[l])
    );
  end

  always_comb begin
    for (int unsigned l = 0; l < N_POLY_SUB; l++) begin
      w_new[l] = (r_tcnt == '0) ? w_x[l] : w_sum[l];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = (i_len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (w_accept && w_last_term && w_last_coef) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ACC: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  // Counters, accumulators and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt       <= '0;
      r_ccnt       <= '0;
      r_len        <= '0;
      r_first_addr <= '0;
      r_we         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      for (int unsigned l = 0; l < N_POLY_SUB; l++) begin
        r_acc[l] <= '0;
      end
    end else begin
      r_we <= '0;
      if ((r_state == IDLE) && i_start) begin
        r_len  <= i_len;
        r_err  <= 1'b0;
        r_tcnt <= '0;
        r_ccnt <= '0;
      end
      if (w_accept) begin
        for (int unsigned l = 0; l < N_POLY_SUB; l++) begin
          r_acc[l] <= w_new[l];
        end
        if (r_tcnt == '0) begin
          r_first_addr <= i_addr;
        end else if (i_addr != r_first_addr) begin
          r_err <= 1'b1;
        end
        if (|w_rng_err) begin
          r_err <= 1'b1;
        end
        if (w_last_term) begin
          r_tcnt <= '0;
          r_ccnt <= r_ccnt + (ADDR_WIDTH+1)'(1);
          r_we   <= '1;
          r_addr <= {N_POLY_SUB{i_addr}};
          for (int unsigned l = 0; l < N_POLY_SUB; l++) begin
            r_data[l*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(w_new[l]);
          end
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_err  = r_err;

endmodule

// File: tb/tb_stg3_acc.sv
module tb_stg3_acc;

  localparam logic [36:0] M0 = 37'h8_0010_0002;  // 2*Q1, lane 0
  localparam logic [36:0] M1 = 37'h8_1000_0002;  // 2*Q0, lane 1

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [12:0]  i_len;
  logic         i_valid;
  logic         o_ready;
  logic [11:0]  i_addr;
  logic [127:0] i_data;
  logic [1:0]   o_we;
  logic [23:0]  o_addr;
  logic [127:0] o_data;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  stg3_acc #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(12),
    .N_POLY_SUB(2),
    .N_TERM(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_len  (i_len),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_addr (i_addr),
    .i_data (i_data),
    .o_we   (o_we),
    .o_addr (o_addr),
    .o_data (o_data),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [35:0] d0;
    logic [35:0] d1;
  } wr_t;

  typedef struct {
    logic [11:0]      addr;
    logic [2:0][35:0] t0;
    logic [2:0][35:0] t1;
    logic [35:0]      e0;
    logic [35:0]      e1;
  } vec_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  busy_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] modsum(input logic [35:0] a, input logic [35:0] b,
                                         input logic [35:0] c, input logic [36:0] m);
    logic [38:0] s;
    s = 39'(a) + 39'(b) + 39'(c);
    return 36'(s % 39'(m));
  endfunction

  // Write monitor: every o_we pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (o_busy) busy_cyc++;
    if (o_we != 2'b00) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {52'd0, o_addr[11:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("we", {62'd0, o_we}, 64'd3);
        chk("addr0", {52'd0, o_addr[11:0]}, {52'd0, e.addr});
        chk("addr1", {52'd0, o_addr[23:12]}, {52'd0, e.addr});
        chk("data0", o_data[63:0], {28'd0, e.d0});
        chk("data1", o_data[127:64], {28'd0, e.d1});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [12:0] len);
    i_start = 1'b1;
    i_len   = len;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic beat(input logic [11:0] a, input logic [35:0] x0, input logic [35:0] x1);
    i_valid = 1'b1;
    i_addr  = a;
    i_data  = {28'd0, x1, 28'd0, x0};
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic push(input logic [11:0] a, input logic [35:0] d0, input logic [35:0] d1);
    wr_t w;
    w.addr = a;
    w.d0   = d0;
    w.d1   = d1;
    sb.push_back(w);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[5];
    int   b0, w0;
    logic [35:0] x0, x1;
    logic [2:0][35:0] r0, r1;

    vt[0] = '{12'h005, {36'h0, 36'h0, 36'h0},
                       {36'h8_1000_0001, 36'h8_1000_0001, 36'h8_1000_0001},
                       36'h0, 36'h8_0FFF_FFFF};
    vt[1] = '{12'h010, {36'd3, 36'd2, 36'd1}, {36'h0, 36'h0, 36'h0}, 36'd6, 36'h0};
    vt[2] = '{12'h011, {36'h0, 36'h1, 36'h8_0010_0001}, {36'h0, 36'h0, 36'h7},
                       36'h0, 36'h7};
    vt[3] = '{12'h7FF, {36'h8_0010_0001, 36'h8_0010_0001, 36'h8_0010_0001},
                       {36'h8_1000_0001, 36'h8_1000_0001, 36'h8_1000_0001},
                       36'h8_000F_FFFF, 36'h8_0FFF_FFFF};
    vt[4] = '{12'hABC, {36'h1, 36'h4_0008_0001, 36'h4_0008_0001},
                       {36'h0, 36'h4_0800_0001, 36'h4_0800_0001},
                       36'h1, 36'h0};

    rst = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0; i_addr = '0; i_data = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_we", {62'd0, o_we}, 64'd0);
    chk("rst_addr", {40'd0, o_addr}, 64'd0);
    chk("rst_data", o_data[63:0] | o_data[127:64], 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd0);

    // Frame len=1, table row 0, then len=4 rows 1..4 with continuous valid
    start(13'd1);
    chk("acc_ready", {63'd0, o_ready}, 64'd1);
    push(vt[0].addr, vt[0].e0, vt[0].e1);
    for (int k = 0; k < 3; k++) beat(vt[0].addr, vt[0].t0[k], vt[0].t1[k]);
    chk("done_len1", {63'd0, o_done}, 64'd1);
    cyc();
    chk("done_len1_off", {63'd0, o_done}, 64'd0);

    start(13'd4);
    b0 = busy_cyc;
    for (int v = 1; v < 5; v++) begin
      push(vt[v].addr, vt[v].e0, vt[v].e1);
      for (int k = 0; k < 3; k++) beat(vt[v].addr, vt[v].t0[k], vt[v].t1[k]);
    end
    chk("done_len4", {63'd0, o_done}, 64'd1);
    chk("err_clean", {63'd0, o_err}, 64'd0);
    cyc();
    chk("busy_cycles", 64'(busy_cyc - b0), 64'd12);
    chk("sb_empty_tbl", 64'(sb.size()), 64'd0);

    // Gapped valid, random in-range data, model = plain sum mod 2Q
    w0 = wr_cnt;
    start(13'd4);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        r0[k] = 36'({$urandom, $urandom} % 64'(M0));
        r1[k] = 36'({$urandom, $urandom} % 64'(M1));
      end
      push(12'(c + 12'h100), modsum(r0[0], r0[1], r0[2], M0), modsum(r1[0], r1[1], r1[2], M1));
      for (int k = 0; k < 3; k++) begin
        beat(12'(c + 12'h100), r0[k], r1[k]);
        if (!(c == 3 && k == 2)) cyc();
      end
    end
    chk("done_gap", {63'd0, o_done}, 64'd1);
    cyc();
    chk("gap_writes", 64'(wr_cnt - w0), 64'd4);

    // Reset after two beats of a group, then a fresh len=1 frame
    w0 = wr_cnt;
    start(13'd1);
    beat(12'h030, 36'd11, 36'd12);
    beat(12'h030, 36'd13, 36'd14);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", {63'd0, o_busy}, 64'd0);
    chk("abort_we", {62'd0, o_we}, 64'd0);
    repeat (2) cyc();
    chk("abort_nodone", {63'd0, o_done}, 64'd0);
    chk("abort_writes", 64'(wr_cnt - w0), 64'd0);
    start(13'd1);
    push(12'h031, 36'd6, 36'd60);
    beat(12'h031, 36'd1, 36'd10);
    beat(12'h031, 36'd2, 36'd20);
    beat(12'h031, 36'd3, 36'd30);
    cyc();
    chk("fresh_writes", 64'(wr_cnt - w0), 64'd1);

    // Address mismatch inside a group: sticky error, write at last address
    start(13'd1);
    push(12'h020, 36'd3, 36'd0);
    beat(12'h020, 36'd1, 36'd0);
    beat(12'h021, 36'd1, 36'd0);
    beat(12'h020, 36'd1, 36'd0);
    chk("err_set", {63'd0, o_err}, 64'd1);
    repeat (3) cyc();
    chk("err_sticky", {63'd0, o_err}, 64'd1);
    start(13'd1);
    chk("err_cleared", {63'd0, o_err}, 64'd0);
    // i_start in ACC must not restart the frame
    push(12'h040, 36'd9, 36'd0);
    beat(12'h040, 36'd4, 36'd0);
    i_start = 1'b1;
    i_len   = 13'd7;
    beat(12'h040, 36'd2, 36'd0);
    i_start = 1'b0;
    beat(12'h040, 36'd3, 36'd0);
    chk("start_ignored_done", {63'd0, o_done}, 64'd1);
    cyc();
    chk("start_ignored_idle", {63'd0, o_busy}, 64'd0);

    // len=0 goes straight to DONE
    w0 = wr_cnt;
    start(13'd0);
    chk("len0_done", {63'd0, o_done}, 64'd1);
    chk("len0_busy", {63'd0, o_busy}, 64'd0);
    cyc();
    chk("len0_done_off", {63'd0, o_done}, 64'd0);
    chk("len0_writes", 64'(wr_cnt - w0), 64'd0);

`ifdef STG3_ACC_IN_CHK_EN
    start(13'd1);
    push(12'h050, 36'd5, 36'd0);
    beat(12'h050, 36'h8_0010_0002, 36'd0);
    beat(12'h050, 36'd5, 36'd0);
    beat(12'h050, 36'd0, 36'd0);
    chk("range_err", {63'd0, o_err}, 64'd1);
    cyc();
`endif

    x0 = '0;
    x1 = '0;
    repeat (3) cyc();
    chk("sb_empty_end", 64'(sb.size()) | {28'd0, x0} | {28'd0, x1}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
